// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the mem_arbiter block.
package mem_arbiter_pkg;

  localparam int unsigned ArbAw = 16;
  localparam int unsigned ArbDw = 16;
  localparam int unsigned PerfW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusyI = 2'b01,
    StBusyD = 2'b10
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low reset and synchronous clear.
module sat_counter #(
  parameter int unsigned     Width = 16,
  parameter logic [Width-1:0] Max  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != Max)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single mem_system, data-priority with starvation guard.
// Define ARB_PERF_CNT_EN to build the grant/conflict performance counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = ArbAw,
  parameter int unsigned DW         = ArbDw,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic [DW-1:0]    if_data,
  output logic             if_done,
  output logic             if_stall,
  input  logic             dm_rd,
  input  logic             dm_wr,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic [DW-1:0]    dm_rdata,
  output logic             dm_done,
  output logic             dm_stall,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_done,
  input  logic             mem_err,
  output logic             err,
  output logic [PerfW-1:0] perf_if_cnt,
  output logic [PerfW-1:0] perf_dm_cnt,
  output logic [PerfW-1:0] perf_conf_cnt
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic          idle, dm_req, dm_illegal, dm_legal, starve_full;
  logic          grant_d, grant_i;
  logic          err_q;

  assign idle        = (state_q == StIdle);
  assign dm_req      = dm_rd | dm_wr;
  assign dm_illegal  = dm_rd & dm_wr;
  assign dm_legal    = dm_req & ~dm_illegal;
  assign starve_full = (starve_cnt == SW'(STARVE_MAX));

  // Data wins a conflict unless fetch has already lost STARVE_MAX in a row.
  assign grant_d = idle & dm_legal & ~(if_req & starve_full);
  assign grant_i = idle & if_req & ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StBusyD;
        end else if (grant_i) begin
          state_d = StBusyI;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    if_data   = '0;
    dm_rdata  = '0;
    unique case (state_q)
      StBusyI: begin
        mem_rd   = 1'b1;
        mem_addr = if_addr;
        if_done  = mem_done;
        if (mem_done) begin
          if_data = mem_rdata;
        end
      end
      StBusyD: begin
        mem_rd    = dm_rd;
        mem_wr    = dm_wr;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        dm_done   = mem_done;
        if (mem_done) begin
          dm_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Stalls are gated by reset so every output reads 0 while rst is low.
  assign if_stall = rst & if_req & ~if_done;
  assign dm_stall = rst & dm_req & ~dm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (dm_illegal || (!idle && mem_err)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  sat_counter #(
    .Width (SW),
    .Max   (SW'(STARVE_MAX))
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant_i),
    .inc   (grant_d & if_req),
    .count (starve_cnt)
  );

`ifdef ARB_PERF_CNT_EN
  sat_counter #(
    .Width (PerfW),
    .Max   ({PerfW{1'b1}})
  ) u_perf_if (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (grant_i),
    .count (perf_if_cnt)
  );

  sat_counter #(
    .Width (PerfW),
    .Max   ({PerfW{1'b1}})
  ) u_perf_dm (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (grant_d),
    .count (perf_dm_cnt)
  );

  sat_counter #(
    .Width (PerfW),
    .Max   ({PerfW{1'b1}})
  ) u_perf_conf (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (idle & if_req & dm_req),
    .count (perf_conf_cnt)
  );
`else
  assign perf_if_cnt   = '0;
  assign perf_dm_cnt   = '0;
  assign perf_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_arbiter;

  localparam int unsigned StarveMax = 4;

  logic        clk, rst;
  logic        if_req, if_done, if_stall;
  logic [15:0] if_addr, if_data;
  logic        dm_rd, dm_wr, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_err, err;
  logic [15:0] perf_if_cnt, perf_dm_cnt, perf_conf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(
    .AW         (16),
    .DW         (16),
    .STARVE_MAX (StarveMax)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_data       (if_data),
    .if_done       (if_done),
    .if_stall      (if_stall),
    .dm_rd         (dm_rd),
    .dm_wr         (dm_wr),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_done       (dm_done),
    .dm_stall      (dm_stall),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .mem_err       (mem_err),
    .err           (err),
    .perf_if_cnt   (perf_if_cnt),
    .perf_dm_cnt   (perf_dm_cnt),
    .perf_conf_cnt (perf_conf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_done  = 1'b0;
    mem_err   = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state for the randomized phase.
  logic [15:0] ref_mem [256];
  bit          f_pend, d_pend, d_wr_op, done_now, exp_if_done, exp_dm_done;
  logic [15:0] f_addr, d_addr, d_wdata;
  int          owner;       // 0 none, 1 fetch, 2 data
  int          starve, busy_cycles, lat_target, pulses;
  int          pi, pd, pc;

  initial begin
    rst = 1'b0;
    clear_inputs();
    apply_reset();

    // Reset state.
    #1;
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_wr", mem_wr, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_done", {if_done, dm_done, if_stall, dm_stall}, 0);
    check_eq("rst_perf", {perf_if_cnt, perf_dm_cnt} | perf_conf_cnt, 0);

    // Fetch-only hit.
    @(negedge clk); if_req = 1; if_addr = 16'h0010; #1;
    check_eq("fh_idle_rd", mem_rd, 0);
    check_eq("fh_stall", if_stall, 1);
    @(negedge clk); #1;
    check_eq("fh_mem_rd", mem_rd, 1);
    check_eq("fh_mem_addr", mem_addr, 16'h0010);
    check_eq("fh_if_data_pre", if_data, 0);
    mem_done = 1; mem_rdata = 16'h0800; #1;
    check_eq("fh_if_done", if_done, 1);
    check_eq("fh_if_data", if_data, 16'h0800);
    check_eq("fh_stall_drop", if_stall, 0);
    @(negedge clk); mem_done = 0; if_req = 0; #1;
    check_eq("fh_after_done", if_done, 0);
    check_eq("fh_after_rd", mem_rd, 0);

    // Conflict: data first, then fetch after an idle cycle.
    @(negedge clk); if_req = 1; if_addr = 16'h0040; dm_rd = 1; dm_addr = 16'h0200; #1;
    check_eq("cf_idle_rd", mem_rd, 0);
    @(negedge clk); #1;
    check_eq("cf_d_addr", mem_addr, 16'h0200);
    check_eq("cf_d_rd", mem_rd, 1);
    mem_done = 1; mem_rdata = 16'h1234; #1;
    check_eq("cf_dm_done", dm_done, 1);
    check_eq("cf_dm_rdata", dm_rdata, 16'h1234);
    check_eq("cf_if_done", if_done, 0);
    check_eq("cf_if_stall", if_stall, 1);
    @(negedge clk); mem_done = 0; dm_rd = 0; #1;
    check_eq("cf_gap_rd", mem_rd, 0);
    @(negedge clk); #1;
    check_eq("cf_i_addr", mem_addr, 16'h0040);
    check_eq("cf_i_rd", mem_rd, 1);
    mem_done = 1; mem_rdata = 16'h5555; #1;
    check_eq("cf_i_done", if_done, 1);
    check_eq("cf_i_data", if_data, 16'h5555);
    @(negedge clk); mem_done = 0; if_req = 0;

    // Starvation: 4 data grants, fetch on the 5th conflict, data again after clear.
    @(negedge clk); if_req = 1; if_addr = 16'h0020; dm_rd = 1; dm_addr = 16'h0300; #1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk); #1;
      check_eq($sformatf("st_grant%0d", g), mem_addr, (g == 4) ? 16'h0020 : 16'h0300);
      mem_done = 1; mem_rdata = 16'(g); #1;
      check_eq($sformatf("st_if_done%0d", g), if_done, (g == 4) ? 1 : 0);
      check_eq($sformatf("st_dm_done%0d", g), dm_done, (g == 4) ? 0 : 1);
      @(negedge clk); mem_done = 0; #1;
      check_eq($sformatf("st_gap%0d", g), mem_rd, 0);
    end
    #1; if_req = 0; dm_rd = 0;

    // Data write, 4-cycle miss.
    @(negedge clk); dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF; pulses = 0; #1;
    check_eq("wm_idle_wr", mem_wr, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); mem_done = (c == 3); #1;
      check_eq($sformatf("wm_wr%0d", c), mem_wr, 1);
      check_eq($sformatf("wm_rd%0d", c), mem_rd, 0);
      check_eq($sformatf("wm_addr%0d", c), mem_addr, 16'h0100);
      check_eq($sformatf("wm_wdata%0d", c), mem_wdata, 16'hBEEF);
      pulses += int'(dm_done);
    end
    @(negedge clk); mem_done = 0; dm_wr = 0; #1;
    pulses += int'(dm_done);
    check_eq("wm_after_wr", mem_wr, 0);
    @(negedge clk); #1;
    pulses += int'(dm_done);
    check_eq("wm_pulses", pulses, 1);

    // Memory error in BUSY_I is sticky.
    apply_reset();
    @(negedge clk); if_req = 1; if_addr = 16'h0030;
    @(negedge clk); mem_done = 1; mem_err = 1; #1;
    check_eq("me_done", if_done, 1);
    @(negedge clk); mem_done = 0; mem_err = 0; if_req = 0; #1;
    check_eq("me_err_set", err, 1);
    @(negedge clk); dm_rd = 1; dm_addr = 16'h0200;
    @(negedge clk); mem_done = 1; #1;
    check_eq("me_dm_done", dm_done, 1);
    @(negedge clk); mem_done = 0; dm_rd = 0; #1;
    check_eq("me_err_sticky", err, 1);

    // Illegal data request: never granted, fetch still served, idle mem_done ignored.
    apply_reset();
    #1;
    check_eq("il_err_clr", err, 0);
    @(negedge clk); dm_rd = 1; dm_wr = 1; if_req = 1; if_addr = 16'h0050;
    @(negedge clk); #1;
    check_eq("il_f_addr", mem_addr, 16'h0050);
    check_eq("il_f_rdwr", {mem_rd, mem_wr}, 2'b10);
    check_eq("il_err", err, 1);
    mem_done = 1; mem_rdata = 16'h0A0A; #1;
    check_eq("il_if_done", if_done, 1);
    check_eq("il_if_data", if_data, 16'h0A0A);
    @(negedge clk); mem_done = 0; if_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_done = (c == 1); #1;
      check_eq($sformatf("il_nogrant%0d", c), {mem_rd, mem_wr, dm_done, if_done}, 0);
    end
    @(negedge clk); mem_done = 0; dm_rd = 0; dm_wr = 0;

    // Async reset mid-miss in BUSY_D.
    apply_reset();
    @(negedge clk); dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
    @(negedge clk); #1;
    check_eq("ar_busy_wr", mem_wr, 1);
    #2; rst = 0; #1;
    check_eq("ar_mem_wr", mem_wr, 0);
    check_eq("ar_mem_addr", mem_addr, 0);
    check_eq("ar_mem_wdata", mem_wdata, 0);
    check_eq("ar_stall", dm_stall, 0);
    @(negedge clk); dm_wr = 0; rst = 1; #1;
    check_eq("ar_rel_wr", mem_wr, 0);
    @(negedge clk); if_req = 1; if_addr = 16'h0060;
    @(negedge clk); #1;
    check_eq("ar_f_rd", mem_rd, 1);
    check_eq("ar_f_addr", mem_addr, 16'h0060);
    mem_done = 1; mem_rdata = 16'h7777; #1;
    check_eq("ar_f_done", if_done, 1);
    check_eq("ar_f_data", if_data, 16'h7777);
    @(negedge clk); mem_done = 0; if_req = 0;

    // Randomized traffic against the reference model.
    apply_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    f_pend = 0; d_pend = 0; d_wr_op = 0; owner = 0; starve = 0;
    busy_cycles = 0; lat_target = 0; pi = 0; pd = 0; pc = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; f_addr = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_wr_op = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if_req = f_pend; if_addr = f_addr;
      dm_rd = d_pend & ~d_wr_op; dm_wr = d_pend & d_wr_op;
      dm_addr = d_addr; dm_wdata = d_wdata;

      done_now = 0;
      if (owner != 0) begin
        done_now = (busy_cycles == lat_target);
        busy_cycles++;
        mem_done = done_now;
      end else begin
        mem_done = ($urandom_range(0, 3) == 0);
      end
      if (owner == 1) mem_rdata = ref_mem[f_addr[7:0]];
      else if (owner == 2 && !d_wr_op) mem_rdata = ref_mem[d_addr[7:0]];
      else mem_rdata = 16'($urandom);
      #1;

      exp_if_done = (owner == 1) && done_now;
      exp_dm_done = (owner == 2) && done_now;
      check_eq("rnd_mem_rd", mem_rd, (owner == 1) || (owner == 2 && !d_wr_op));
      check_eq("rnd_mem_wr", mem_wr, (owner == 2) && d_wr_op);
      check_eq("rnd_mem_addr", mem_addr, (owner == 1) ? f_addr : (owner == 2) ? d_addr : 16'h0);
      check_eq("rnd_mem_wdata", mem_wdata, (owner == 2) ? d_wdata : 16'h0);
      check_eq("rnd_if_done", if_done, exp_if_done);
      check_eq("rnd_dm_done", dm_done, exp_dm_done);
      check_eq("rnd_if_data", if_data, exp_if_done ? mem_rdata : 16'h0);
      check_eq("rnd_dm_rdata", dm_rdata, exp_dm_done ? mem_rdata : 16'h0);
      check_eq("rnd_if_stall", if_stall, f_pend && !exp_if_done);
      check_eq("rnd_dm_stall", dm_stall, d_pend && !exp_dm_done);

      if (owner != 0) begin
        if (done_now) begin
          if (owner == 1) begin
            f_pend = 0;
          end else begin
            if (d_wr_op) ref_mem[d_addr[7:0]] = d_wdata;
            d_pend = 0;
          end
          owner = 0;
        end
      end else begin
        if (f_pend && d_pend) pc++;
        if (d_pend && !(f_pend && starve == StarveMax)) begin
          owner = 2; pd++;
          if (f_pend && starve < StarveMax) starve++;
        end else if (f_pend) begin
          owner = 1; pi++; starve = 0;
        end
        busy_cycles = 0;
        lat_target = $urandom_range(0, 3);
      end
    end
    @(negedge clk); #1;
    check_eq("rnd_err", err, 0);
`ifdef ARB_PERF_CNT_EN
    check_eq("perf_if", perf_if_cnt, pi);
    check_eq("perf_dm", perf_dm_cnt, pd);
    check_eq("perf_conf", perf_conf_cnt, pc);
`else
    check_eq("perf_if_off", perf_if_cnt, 0);
    check_eq("perf_dm_off", perf_dm_cnt, 0);
    check_eq("perf_conf_off", perf_conf_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
